fft_sdf_ctrl: RTL and testbench
===============================

FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

Interface
REQ-001 SHALL have parameter N_POINTS, default 16, FFT size; power of 2, at least 4.
REQ-002 SHALL have parameter N_STAGES, default $clog2(N_POINTS), number of radix-2 butterfly stages driven.
REQ-003 SHALL have derived localparam LAT = N_POINTS-1+N_STAGES, the pipeline latency in enable cycles.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream sample available.
REQ-007 SHALL have port in_ready, output, 1, controller accepts a sample this cycle.
REQ-008 SHALL have port en, output, 1, pipeline-wide enable to every butterfly stage.
REQ-009 SHALL have port zero_fill, output, 1, datapath input mux selects zero (flush).
REQ-010 SHALL have port ctrl, output, N_STAGES, per-stage control_bit (0 = fill buffer, 1 = add/subtract).
REQ-011 SHALL have port out_valid, output, 1, last-stage output register holds a valid result.
REQ-012 SHALL have port out_first, output, 1, first result of a frame.
REQ-013 SHALL have port out_last, output, 1, last result of a frame.
REQ-014 SHALL have port out_idx, output, N_STAGES, natural-order frequency bin of the current result.
REQ-015 SHALL have port busy, output, 1, state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
- IDLE->RUN on accepted sample.
- RUN->FLUSH when sample N-1 of a frame is accepted and in_valid is 0 on the next cycle.
- FLUSH->IDLE after LAT flush cycles.
REQ-017 SHALL drive in_ready=1 in IDLE and RUN and in_ready=0 in FLUSH; accept = in_valid & in_ready.
REQ-018 SHALL drive en=accept in IDLE/RUN and en=1 every FLUSH cycle; zero_fill=1 exactly in FLUSH.
REQ-019 SHALL keep sample counter cnt (N_STAGES bits, modulo N_POINTS), incremented on every en cycle, wrapping N-1->0, and held when en=0.
REQ-020 SHALL compute ctrl[s] combinationally as bit (N_STAGES-1-s) of ((cnt - s) mod N_POINTS), for s = 0..N_STAGES-1; the offset s models one register per preceding stage.
REQ-021 SHALL keep fill counter fcnt, saturating at LAT, incremented per en cycle, cleared on entering IDLE.
REQ-022 SHALL register out_valid<=1 on the clock edge of any en cycle in which fcnt already equals LAT, else 0.
- Fixes result timing at the (LAT+1)-th en cycle after the first accept.
REQ-023 SHALL keep output order counter ocnt (N_STAGES bits), incremented on each out_valid, wrapping, cleared on entering IDLE.
REQ-024 SHALL drive out_idx = bit-reverse(ocnt), out_first = out_valid & (ocnt==0), out_last = out_valid & (ocnt==N-1).
REQ-025 SHALL stall on a mid-frame in_valid gap in RUN: en=0, cnt/fcnt/ocnt/ctrl held, out_valid=0, state stays RUN.
REQ-026 SHALL NOT enter FLUSH between back-to-back frames (in_valid high at wrap); streaming is continuous across frames.
REQ-027 SHALL ignore in_valid during FLUSH; the first sample after FLUSH is accepted in IDLE on the cycle after the FLUSH->IDLE transition.
REQ-028 SHALL use a flush-cycle counter in FLUSH that counts 0..LAT-1; transition to IDLE occurs on the edge ending cycle LAT-1.

Reset
REQ-029 SHALL, while rst=1 (asynchronous, any time including mid-frame or mid-FLUSH), force state IDLE; cnt, fcnt, ocnt and flush counter 0; out_valid, out_first, out_last, out_idx, en, zero_fill, busy 0; in_ready 1; ctrl = value for cnt=0.
REQ-030 SHALL release from reset synchronously on the first rising edge after rst falls, with no spurious en.

Verification
REQ-031 Reset mid-RUN (N=16, after sample 7) -> next cycle: busy=0, in_ready=1, out_valid=0, cnt=0; next frame is processed as a new frame.
REQ-032 Single frame, N=16: in_valid high for 16 cycles, then low -> 16 accepts, then 19 FLUSH cycles (zero_fill=1, in_ready=0, en=1); out_valid high for 16 cycles starting after en cycle 20; out_first with out_idx=0; out_last with out_idx=15; then IDLE.
REQ-033 Ctrl pattern, continuous stream, N=16 -> ctrl[0]=0 for cnt 0..7 and 1 for cnt 8..15; ctrl[1]=1 when (cnt-1) mod 16 is in 4..7 or 12..15; ctrl[3]=1 when (cnt-3) is odd.
REQ-034 Stall of 3 cycles after sample 5 -> en=0 and ctrl, cnt, fcnt held for 3 cycles; outputs identical to the unstalled run, shifted by 3 cycles.
REQ-035 Two back-to-back frames (32 consecutive accepts) -> no FLUSH between frames; 32 consecutive out_valid cycles; out_last at ocnt 15 is followed directly by out_first; single FLUSH of 19 cycles at the end.
REQ-036 in_valid held high through FLUSH -> in_ready=0, no accept during FLUSH; accept occurs on the first IDLE cycle, with cnt=0 and fcnt=0.

Source files
------------

// File: rtl/fft_sdf_ctrl.sv
// Sequencing controller for a radix-2 single-path delay-feedback FFT pipeline.
// Generates the stage enable, per-stage butterfly control, flush and output framing.
module fft_sdf_ctrl #(
    parameter int N_POINTS = 16,
    parameter int N_STAGES = $clog2(N_POINTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                en,
    output logic                zero_fill,
    output logic [N_STAGES-1:0] ctrl,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic [N_STAGES-1:0] out_idx,
    output logic                busy
);
    localparam int LAT = N_POINTS - 1 + N_STAGES;
    localparam int FW  = $clog2(LAT + 1);
    localparam logic [FW-1:0]       LAT_F    = FW'(LAT);
    localparam logic [FW-1:0]       LAT_M1   = FW'(LAT - 1);
    localparam logic [N_STAGES-1:0] CNT_ZERO = {N_STAGES{1'b0}};
    localparam logic [N_STAGES-1:0] CNT_LAST = N_STAGES'(N_POINTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic                en_s;
    logic                to_idle_s;
    logic [N_STAGES-1:0] cnt_r;
    logic [N_STAGES-1:0] ocnt_r;
    logic [FW-1:0]       fcnt_r;
    logic [FW-1:0]       flush_r;
    logic                out_valid_r;
    logic [N_STAGES-1:0] diff_s;

    function automatic logic [N_STAGES-1:0] bit_reverse(input logic [N_STAGES-1:0] v);
        logic [N_STAGES-1:0] r;
        r = {N_STAGES{1'b0}};
        for (int i = 0; i < N_STAGES; i++) begin
            r[i] = v[N_STAGES-1-i];
        end
        return r;
    endfunction

    // Next-state and handshake/enable decode
    always_comb begin
        state_nx_s = state_r;
        in_ready   = 1'b1;
        en_s       = 1'b0;
        zero_fill  = 1'b0;
        case (state_r)
            IDLE: begin
                en_s = in_valid;
                if (in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                en_s = in_valid;
                // A gap exactly at a frame boundary ends the stream.
                if (!in_valid && (cnt_r == CNT_ZERO)) begin
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = RUN;
                end
            end
            FLUSH: begin
                in_ready  = 1'b0;
                en_s      = 1'b1;
                zero_fill = 1'b1;
                if (flush_r == LAT_M1) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = FLUSH;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    assign to_idle_s = (state_r == FLUSH) && (state_nx_s == IDLE);
    assign en        = en_s & ~rst;
    assign busy      = (state_r != IDLE);

    // Per-stage butterfly control; stage s sees the counter delayed by s registers
    always_comb begin
        ctrl   = {N_STAGES{1'b0}};
        diff_s = {N_STAGES{1'b0}};
        for (int s = 0; s < N_STAGES; s++) begin
            diff_s  = cnt_r - N_STAGES'(s);
            ctrl[s] = diff_s[N_STAGES-1-s];
        end
    end

    // State, counters and output-valid register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            fcnt_r      <= {FW{1'b0}};
            flush_r     <= {FW{1'b0}};
            ocnt_r      <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= en_s && (fcnt_r == LAT_F);

            if (to_idle_s) begin
                cnt_r  <= CNT_ZERO;
                fcnt_r <= {FW{1'b0}};
            end else if (en_s) begin
                cnt_r <= cnt_r + N_STAGES'(1);
                if (fcnt_r != LAT_F) begin
                    fcnt_r <= fcnt_r + FW'(1);
                end else begin
                    fcnt_r <= fcnt_r;
                end
            end else begin
                cnt_r  <= cnt_r;
                fcnt_r <= fcnt_r;
            end

            if ((state_r == FLUSH) && (flush_r != LAT_M1)) begin
                flush_r <= flush_r + FW'(1);
            end else begin
                flush_r <= {FW{1'b0}};
            end

            // The last result of a flush is still presented in the first IDLE cycle.
            if (out_valid_r) begin
                ocnt_r <= ocnt_r + N_STAGES'(1);
            end else if (state_r == IDLE) begin
                ocnt_r <= CNT_ZERO;
            end else begin
                ocnt_r <= ocnt_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_idx   = bit_reverse(ocnt_r);
    assign out_first = out_valid_r & (ocnt_r == CNT_ZERO);
    assign out_last  = out_valid_r & (ocnt_r == CNT_LAST);

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Randomized bench for fft_sdf_ctrl against a transaction-level model of the
// frame/flush behaviour (enable counts, flush length, output numbering).
module tb_fft_sdf_ctrl;
    localparam int N   = 16;
    localparam int NS  = 4;
    localparam int LAT = N - 1 + NS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          en;
    logic          zero_fill;
    logic [NS-1:0] ctrl;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic [NS-1:0] out_idx;
    logic          busy;

    fft_sdf_ctrl #(.N_POINTS(N), .N_STAGES(NS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .en(en), .zero_fill(zero_fill), .ctrl(ctrl), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .out_idx(out_idx), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = idle, 1 = streaming, 2 = flushing
    int m_state  = 0;
    int m_en_cnt = 0;   // enable cycles since the stream started
    int m_flush  = 0;   // flush cycles completed
    int m_outs   = 0;   // results delivered since reset
    bit m_ov     = 1'b0;

    int obs_zf, obs_ov, obs_first, obs_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] exp_ctrl(input int c);
        logic [NS-1:0] r;
        int d;
        r = '0;
        for (int s = 0; s < NS; s++) begin
            d = ((c - s) % N + N) % N;
            r[s] = ((d >> (NS - 1 - s)) & 1) != 0;
        end
        return r;
    endfunction

    function automatic logic [NS-1:0] exp_rev(input int k);
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            r[NS-1-i] = ((k >> i) & 1) != 0;
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic r);
        bit e_en, new_ov, to_idle;
        int ocnt;
        @(negedge clk);
        in_valid = v;
        rst      = r;
        if (r) begin
            m_state = 0; m_en_cnt = 0; m_flush = 0; m_outs = 0; m_ov = 1'b0;
        end
        #1;
        e_en = r ? 1'b0 : ((m_state == 2) ? 1'b1 : v);
        ocnt = m_outs % N;
        check_eq("in_ready", in_ready, (m_state != 2));
        check_eq("en", en, e_en);
        check_eq("zero_fill", zero_fill, (m_state == 2));
        check_eq("busy", busy, (m_state != 0));
        check_eq("ctrl", ctrl, exp_ctrl(m_en_cnt % N));
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_idx", out_idx, exp_rev(ocnt));
        check_eq("out_first", out_first, m_ov && (ocnt == 0));
        check_eq("out_last", out_last, m_ov && (ocnt == N - 1));
        obs_zf    += int'(zero_fill);
        obs_ov    += int'(out_valid);
        obs_first += int'(out_first);
        obs_last  += int'(out_last);
        @(posedge clk);
        if (!r) begin
            new_ov  = e_en && (m_en_cnt >= LAT);
            to_idle = 1'b0;
            if (m_ov) m_outs++;
            case (m_state)
                0: if (v) m_state = 1;
                1: if (!v && (m_en_cnt % N == 0)) m_state = 2;
                2: begin
                    m_flush++;
                    if (m_flush == LAT) begin
                        m_state = 0; m_flush = 0; to_idle = 1'b1;
                    end
                end
                default: m_state = 0;
            endcase
            if (e_en) m_en_cnt++;
            if (to_idle) m_en_cnt = 0;
            m_ov = new_ov;
        end
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    task automatic clear_obs();
        obs_zf = 0; obs_ov = 0; obs_first = 0; obs_last = 0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        clear_obs();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Single frame followed by its flush
        clear_obs();
        run(1'b1, N);
        run(1'b0, 45);
        check_eq("single_flush_len", obs_zf, LAT);
        check_eq("single_out_cnt", obs_ov, N);
        check_eq("single_first_last", {obs_first[15:0], obs_last[15:0]}, {16'd1, 16'd1});

        // Two frames back to back, one flush at the end
        clear_obs();
        run(1'b1, 2 * N);
        run(1'b0, 45);
        check_eq("b2b_flush_len", obs_zf, LAT);
        check_eq("b2b_out_cnt", obs_ov, 2 * N);

        // Mid-frame stall of 3 cycles after sample 5
        clear_obs();
        run(1'b1, 5);
        run(1'b0, 3);
        run(1'b1, N - 5);
        run(1'b0, 45);
        check_eq("stall_out_cnt", obs_ov, N);

        // in_valid held high through flush; new frame starts right after
        run(1'b1, N);
        run(1'b0, 1);
        run(1'b1, LAT + 2 * N);
        run(1'b0, 45);

        // Reset in the middle of a frame, then a fresh frame
        run(1'b1, 8);
        step(1'b1, 1'b1);
        run(1'b1, N);
        run(1'b0, 45);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end
        run(1'b0, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
